tnoc_axi_write_read_arbiter: RTL

//  Packet-atomic arbiter and outstanding-transaction controller on the AXI-adapter

---
 rtl/tnoc_axi_write_read_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/tnoc_axi_write_read_arbiter.sv
// Packet-atomic write/read arbiter with per-source outstanding-response throttling.
// Optional qos priority in IDLE: define TNOC_AXI_WRITE_READ_ARBITER_QOS_EN.
// Optional protocol checks: define TNOC_AXI_WRITE_READ_ARBITER_CHECKS.
//
// state     | meaning
// IDLE      | no packet open; grant is combinational from eligibility
// WRITE_PKT | write packet in progress, grant locked on write until tail accepted
// READ_PKT  | read packet in progress, grant locked on read until tail accepted
module tnoc_axi_write_read_arbiter #(
   parameter int MAX_OUTSTANDING = 8,
   parameter int COUNT_WIDTH     = $clog2(MAX_OUTSTANDING + 1),
   parameter int QOS_WIDTH       = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [1:0]             i_request,
   input  logic [1:0]             i_head,
   input  logic [1:0]             i_tail,
   input  logic                   i_accept,
   input  logic [1:0]             i_response_done,
   input  logic [QOS_WIDTH-1:0]   i_write_qos,
   input  logic [QOS_WIDTH-1:0]   i_read_qos,
   output logic [1:0]             o_grant,
   output logic                   o_locked,
   output logic [COUNT_WIDTH-1:0] o_write_outstanding,
   output logic [COUNT_WIDTH-1:0] o_read_outstanding
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITE_PKT = 2'd1,
      READ_PKT  = 2'd2
   } state_t;

   localparam logic [COUNT_WIDTH-1:0] MAX_CNT = COUNT_WIDTH'(MAX_OUTSTANDING);
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic                   r_rr_last;
   logic [COUNT_WIDTH-1:0] r_write_count;
   logic [COUNT_WIDTH-1:0] r_read_count;
   logic [1:0]             w_eligible;
   logic                   w_pick_read;
   logic [1:0]             w_grant;
   logic                   w_locked;
   logic                   w_head_acc;
   logic                   w_sel_read;
   logic                   w_inc_write;
   logic                   w_inc_read;
   logic                   w_dec_write;
   logic                   w_dec_read;

   assign w_eligible[0] = i_request[0] & i_head[0] & (r_write_count < MAX_CNT);
   assign w_eligible[1] = i_request[1] & i_head[1] & (r_read_count  < MAX_CNT);

   // r_rr_last = 1 means read won last, so a tie goes to write.
   always_comb begin
      w_pick_read = 1'b0;
      if (&w_eligible) begin
`ifdef TNOC_AXI_WRITE_READ_ARBITER_QOS_EN
         if (i_write_qos > i_read_qos) begin
            w_pick_read = 1'b0;
         end else if (i_read_qos > i_write_qos) begin
            w_pick_read = 1'b1;
         end else begin
            w_pick_read = ~r_rr_last;
         end
`else
         w_pick_read = ~r_rr_last;
`endif
      end else begin
         w_pick_read = w_eligible[1];
      end
   end

`ifndef TNOC_AXI_WRITE_READ_ARBITER_QOS_EN
   logic w_unused_qos;
   assign w_unused_qos = ^{i_write_qos, i_read_qos};
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 2'b00;
      w_locked    = 1'b0;
      w_head_acc  = 1'b0;
      case (r_state)
         IDLE: begin
            if (|w_eligible) begin
               w_grant = w_pick_read ? 2'b10 : 2'b01;
            end
            w_head_acc = (|w_grant) & i_accept;
            if (w_head_acc && !i_tail[w_pick_read]) begin
               w_state_nxt = w_pick_read ? READ_PKT : WRITE_PKT;
            end
         end
         WRITE_PKT: begin
            w_grant  = 2'b01;
            w_locked = 1'b1;
            if (i_accept && i_tail[0]) begin
               w_state_nxt = IDLE;
            end
         end
         READ_PKT: begin
            w_grant  = 2'b10;
            w_locked = 1'b1;
            if (i_accept && i_tail[1]) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign w_sel_read  = w_grant[1];
   assign w_inc_write = w_head_acc & ~w_sel_read;
   assign w_inc_read  = w_head_acc &  w_sel_read;
   // A response with nothing outstanding is dropped so the counter cannot wrap.
   assign w_dec_write = i_response_done[0] & (r_write_count != '0);
   assign w_dec_read  = i_response_done[1] & (r_read_count  != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_rr_last <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         if (w_head_acc) begin
            r_rr_last <= w_sel_read;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_write_count <= '0;
         r_read_count  <= '0;
      end else begin
         case ({w_inc_write, w_dec_write})
            2'b10:   r_write_count <= r_write_count + CNT_ONE;
            2'b01:   r_write_count <= r_write_count - CNT_ONE;
            default: r_write_count <= r_write_count;
         endcase
         case ({w_inc_read, w_dec_read})
            2'b10:   r_read_count <= r_read_count + CNT_ONE;
            2'b01:   r_read_count <= r_read_count - CNT_ONE;
            default: r_read_count <= r_read_count;
         endcase
      end
   end

   assign o_grant             = w_grant;
   assign o_locked            = w_locked;
   assign o_write_outstanding = r_write_count;
   assign o_read_outstanding  = r_read_count;

`ifdef TNOC_AXI_WRITE_READ_ARBITER_CHECKS
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!((r_state == IDLE) && |(i_request & ~i_head)))
            else $error("request without head flit at packet boundary");
         assert (!(i_response_done[0] && (r_write_count == '0)))
            else $error("write response with no write outstanding");
         assert (!(i_response_done[1] && (r_read_count == '0)))
            else $error("read response with no read outstanding");
      end
   end
`endif

endmodule
